// File: rtl/reg_file_p_pkg.sv
// Shared definitions for the parametrised register file: architectural register
// addresses and the init-sequencer state encoding.
package reg_file_p_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_US   = 1;
    localparam int unsigned REG_S0   = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } init_state_e;

endpackage

// File: rtl/reg_file_p_if.sv
// Datapath bundle between decode/writeback and the register file, plus the
// board-facing LED mirror and ready flag.
interface reg_file_p_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned STATUS_W = 4,
    parameter int unsigned LED_W    = 8
);
    logic                we;
    logic [ADDR_W-1:0]   wa;
    logic [DATA_W-1:0]   wd;
    logic [ADDR_W-1:0]   ra1;
    logic [ADDR_W-1:0]   ra2;
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   rd1;
    logic [DATA_W-1:0]   rd2;
    logic [LED_W-1:0]    leds;
    logic                ready;

    modport master (
        output we, wa, wd, ra1, ra2, status,
        input  rd1, rd2, leds, ready
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, status,
        output rd1, rd2, leds, ready
    );
endinterface

// File: rtl/reg_file_p_rf_init_seq.sv
// Post-reset clear sequencer: walks a pointer over every array entry, then
// parks in RUN and raises ready until the next reset.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_CLEAR | writing zero to rf[ptr] each cycle, reads forced to 0
//   ST_RUN   | array initialised, architectural writes accepted
module rf_init_seq
    import reg_file_p_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        clr_we   = (state_q == ST_CLEAR);
        clr_addr = ptr_q;
        ready    = (state_q == ST_RUN);
    end

endmodule

// File: rtl/reg_file_p.sv
// Parametrised MIPS general-purpose register file with a status read-only slot,
// an LED mirror register, optional write-to-read bypass and a post-reset clear.
module reg_file_p
    import reg_file_p_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 32,
    parameter int unsigned       ADDR_W      = 5,
    parameter int unsigned       STATUS_W    = 4,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(REG_US),
    parameter logic [ADDR_W-1:0] LED_ADDR    = ADDR_W'(REG_S0),
    parameter int unsigned       LED_W       = 8,
    parameter bit                BYPASS      = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_p_if.slave  bus
);

    localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    rf_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // No reset on the array so it can map onto distributed RAM; the sequencer clears it.
    logic [DATA_W-1:0] rf_q [DEPTH];

    logic              wr_eff;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wd;
    logic [LED_W-1:0]  leds_d, leds_q;
    logic [DATA_W-1:0] status_ext;

    assign status_ext = DATA_W'(bus.status);

    always_comb begin
        wr_eff  = ready && bus.we && (bus.wa != ZERO_ADDR) && (bus.wa != STATUS_ADDR)
                  && ({1'b0, bus.wa} < DEPTH_EXT);
        arr_we  = clr_we || wr_eff;
        arr_idx = clr_we ? clr_addr[IDX_W-1:0] : bus.wa[IDX_W-1:0];
        arr_wd  = clr_we ? '0 : bus.wd;
        leds_d  = leds_q;
        if (wr_eff && (bus.wa == LED_ADDR)) begin
            leds_d = bus.wd[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            rf_q[arr_idx] <= arr_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] arr_val,
        input logic              rdy,
        input logic              hit,
        input logic [DATA_W-1:0] st,
        input logic [DATA_W-1:0] wdat
    );
        logic [DATA_W-1:0] r;
        if (!rdy || (ra == ZERO_ADDR)) begin
            r = '0;
        end else if (ra == STATUS_ADDR) begin
            r = st;
        end else if ({1'b0, ra} >= DEPTH_EXT) begin
            r = '0;
        end else if (hit) begin
            r = wdat;
        end else begin
            r = arr_val;
        end
        return r;
    endfunction

    logic hit1, hit2;

    assign hit1 = BYPASS && wr_eff && (bus.wa == bus.ra1);
    assign hit2 = BYPASS && wr_eff && (bus.wa == bus.ra2);

    assign bus.rd1   = rd_sel(bus.ra1, rf_q[bus.ra1[IDX_W-1:0]], ready, hit1, status_ext, bus.wd);
    assign bus.rd2   = rd_sel(bus.ra2, rf_q[bus.ra2[IDX_W-1:0]], ready, hit2, status_ext, bus.wd);
    assign bus.leds  = leds_q;
    assign bus.ready = ready;

endmodule

// File: doc/reg_file_p.md
# reg_file_p

Parametrised general-purpose register file for the single-cycle MIPS core, the next generation of the 32x32 register file. Width, depth, status-register address and LED-mirror address are parameters. Reset is real: an init sequencer clears the array after reset and signals `ready`. Optional write-to-read bypass. Sits between decode (read addresses) and writeback (write port), and drives the board LEDs and UART statistic injection.

## Interface
- `DATA_W`, 32, register width in bits
- `DEPTH`, 32, number of architectural registers (1..2**ADDR_W)
- `ADDR_W`, 5, address width of `ra1`/`ra2`/`wa`
- `STATUS_W`, 4, width of `status` input
- `STATUS_ADDR`, 5'd1 (`US` from the shared include), read-only address returning `status`
- `LED_ADDR`, 5'd16 (`S0` from the shared include), register mirrored onto `leds`
- `LED_W`, 8, width of `leds`
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `we`  in  1  write enable
- `wa`  in  ADDR_W  write address
- `wd`  in  DATA_W  write data
- `ra1`, `ra2`  in  ADDR_W  read addresses
- `status`  in  STATUS_W  live status word (UART statistics)
- `rd1`, `rd2`  out  DATA_W  read data, combinational
- `leds`  out  LED_W  registered mirror of `LED_ADDR` low bits
- `ready`  out  1  high once the init sequence has completed

## Operation
- Init FSM states: CLEAR, RUN.
- `rst` high: state=CLEAR, ptr=0, `ready`=0, `leds`=0, asynchronously.
- CLEAR: each cycle writes 0 to rf[ptr], ptr++. When ptr==DEPTH-1 the write happens and state goes to RUN.
- RUN: `ready`=1. Terminal state until the next `rst`.
- In CLEAR, `we` is ignored. `rd1`/`rd2` return 0 regardless of address.
- The write in RUN is `we` && wa!=0 && wa!=STATUS_ADDR && wa<DEPTH. It updates rf[wa] at the edge.
- Writes to address 0, to STATUS_ADDR, or to wa>=DEPTH are silently dropped.
- If the write hits LED_ADDR, `leds` <= wd[LED_W-1:0] on the same edge.
- Read priority per port, with ra as the port address:
  - ra==0 -> 0
  - ra==STATUS_ADDR -> status zero-extended to DATA_W
  - ra>=DEPTH -> 0
  - BYPASS && effective write && wa==ra -> wd
  - otherwise rf[ra]
- Both ports are independent. Identical addresses on both ports return identical data.

## Timing
- CLEAR lasts exactly DEPTH cycles after `rst` deasserts. `ready` rises after the DEPTH-th rising edge.
- `rst` asserted mid-CLEAR restarts from ptr=0. `rst` in RUN re-enters CLEAR; array contents are then zeroed again.
- Write latency: 1 edge. With BYPASS=0, a read of wa in the write cycle returns the old value, and the new value appears in the next cycle.
- With BYPASS=1, the new value appears combinationally in the same cycle.
- `leds` updates on the write edge. It is never driven combinationally from `wd`.
- Read path is purely combinational from ra/status/array. No read latency.
- `status` changes propagate to reads in the same cycle.

## Structure
- Shared include `./include/registers.v` holds the register-address macros (`US`, `S0`, `ZERO`). Parameter defaults are taken from it.
- Sub-module `rf_init_seq`: the CLEAR/RUN FSM plus pointer. Outputs `clr_we`, `clr_addr`, `ready`.
- The top level muxes the init write port with the architectural write port.
- Array is a plain `reg [DATA_W-1:0] rf [DEPTH-1:0]`. There is no async reset on the array, which keeps it mappable to distributed RAM.

## Test plan
- Reset then count: release `rst`, hold `we`=1, wd=32'hFFFF_FFFF. Expected: `ready`=0 for exactly 32 cycles, then 1. All reads return 0; no register is written during CLEAR.
- Basic write/read, BYPASS=0: write 32'hDEAD_BEEF to r8. Expected: rd1 with ra1=8 reads old 0 in the write cycle, then 32'hDEAD_BEEF the next cycle.
- Bypass, BYPASS=1: same stimulus. Expected: rd1=32'hDEAD_BEEF in the write cycle. Write to r0 with wd=5, ra2=0 in the same cycle: rd2=0.
- Status/LED: status=4'hA, ra1=STATUS_ADDR. Expected: rd1=32'h0000_000A.
  - Then write 32'h1234_56C3 to STATUS_ADDR: dropped, and rd1 still reads 32'h0000_000A.
  - Then write 32'h1234_56C3 to LED_ADDR: `leds`=8'hC3 after the edge.
- Reset mid-operation: assert `rst` on cycle 10 of CLEAR. Expected: `leds`=0 immediately and `ready`=0.
  - A full 32-cycle CLEAR follows after release.
  - A register written before the reset then reads 0.
- Small config: DEPTH=8, ADDR_W=5. Expected: write to wa=20 is dropped; ra1=20 reads 0. CLEAR lasts 8 cycles.
